// File: rtl/execute_issue_ctrl.sv
// -----------------------------------------------------------------------------
// execute_issue_ctrl
//   X-stage control for the 32-bit pipeline. Decodes the X-stage instruction
//   (type, ALU opcode, shift amount, B-operand select) and sequences the
//   multi-cycle mult/div unit: start pulse, X-stage stall, flush abort,
//   drain of an orphaned operation, and hung-unit timeout.
//
// Ports
//   clock          in   1      rising-edge clock
//   reset_n        in   1      asynchronous active-low reset
//   ins            in   INS_W  instruction in X stage
//   ins_valid      in   1      ins is a real instruction (not a bubble)
//   flush          in   1      branch/jump flush of X stage this cycle
//   multdiv_done   in   1      multdiv result ready (1-cycle pulse)
//   insType        out  2      00 R, 01 I, 10 JI, 11 JII
//   aluOpCode      out  5      ins[6:2] when R-type, else 0
//   shiftAmt       out  5      ins[11:7]
//   aluBSelector   out  1      1 = immediate operand
//   startMult      out  1      1-cycle start pulse to multiplier
//   startDiv       out  1      1-cycle start pulse to divider
//   stall          out  1      hold F/D/X latches this cycle
//   md_busy        out  1      FSM in BUSY or DRAIN
//   md_timeout     out  1      sticky: unit exceeded TIMEOUT
//   busy_cnt       out  CNT_W  cycles spent in current BUSY/DRAIN episode
// -----------------------------------------------------------------------------
module execute_issue_ctrl #(
  parameter int         INS_W   = 32,
  parameter logic [4:0] MULT_OP = 5'b00110,
  parameter logic [4:0] DIV_OP  = 5'b00111,
  parameter int         TIMEOUT = 64,
  parameter int         CNT_W   = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [INS_W-1:0] ins,
  input  logic             ins_valid,
  input  logic             flush,
  input  logic             multdiv_done,
  output logic [1:0]       insType,
  output logic [4:0]       aluOpCode,
  output logic [4:0]       shiftAmt,
  output logic             aluBSelector,
  output logic             startMult,
  output logic             startDiv,
  output logic             stall,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] busy_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  localparam logic [1:0]       TYPE_R   = 2'b00;
  localparam logic [1:0]       TYPE_I   = 2'b01;
  localparam logic [1:0]       TYPE_JI  = 2'b10;
  localparam logic [1:0]       TYPE_JII = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [4:0]       w_opcode;
  logic             w_md_req;
  logic             w_is_mult;
  logic             w_at_limit;
  logic             w_unused_bits;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_busy_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  assign w_opcode      = ins[INS_W-1 -: 5];
  assign w_unused_bits = ^ins[INS_W-6:12] ^ ins[1] ^ ins[0];

  // Instruction type decode; unlisted opcodes are treated as I-type.
  always_comb begin
    insType = TYPE_I;
    case (w_opcode)
      5'b00000:                                     insType = TYPE_R;
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: insType = TYPE_I;
      5'b00001, 5'b00011, 5'b10110, 5'b10101:      insType = TYPE_JI;
      5'b00100:                                     insType = TYPE_JII;
      default:                                      insType = TYPE_I;
    endcase
  end

  // ALU field decode; bne/blt compare two registers, so they keep B = register.
  always_comb begin
    aluOpCode    = 5'd0;
    shiftAmt     = ins[11:7];
    aluBSelector = 1'b0;
    if (insType == TYPE_R) begin
      aluOpCode = ins[6:2];
    end else begin
      aluOpCode = 5'd0;
    end
    if ((insType == TYPE_I) && (w_opcode != 5'b00010) && (w_opcode != 5'b00110)) begin
      aluBSelector = 1'b1;
    end else begin
      aluBSelector = 1'b0;
    end
  end

  // reset_n gates the request so no start or stall can escape while reset is held.
  assign w_md_req   = reset_n & ins_valid & ~flush & (insType == TYPE_R) &
                      ((aluOpCode == MULT_OP) | (aluOpCode == DIV_OP));
  assign w_is_mult  = (aluOpCode == MULT_OP);
  assign w_at_limit = (r_busy_cnt == CNT_LAST);

  // Next-state, counter, sticky timeout and Mealy start/stall outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_busy_cnt;
    w_timeout_nxt = r_timeout;
    startMult     = 1'b0;
    startDiv      = 1'b0;
    stall         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_md_req) begin
          startMult   = w_is_mult;
          startDiv    = ~w_is_mult;
          stall       = 1'b1;
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      ST_BUSY: begin
        // Priority: done > flush > timeout.
        if (multdiv_done) begin
          stall       = 1'b0;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (flush) begin
          // Unit keeps running; its result is discarded in DRAIN.
          stall       = 1'b0;
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = r_busy_cnt + CNT_ONE;
        end else if (w_at_limit) begin
          stall         = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = CNT_ZERO;
        end else begin
          stall     = 1'b1;
          w_cnt_nxt = r_busy_cnt + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        // Only a new mult/div has to wait for the orphaned op to finish.
        stall = w_md_req;
        if (multdiv_done) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_at_limit) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_busy_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and sticky timeout registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_busy_cnt <= CNT_ZERO;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign md_busy    = (r_state == ST_BUSY) | (r_state == ST_DRAIN);
  assign md_timeout = r_timeout;
  assign busy_cnt   = r_busy_cnt;

endmodule
